mem_port_arbiter: RTL and testbench

- Shares one physical memory port between the pipeline's instruction port (A, read-only) and data port (B, read/write).
- Sits between the CPU's fetch/mem stages and the single memory/L2 interface.
- Grants one requester at a time, forwards its request unchanged, and returns a one-cycle resp pulse with registered read data.
- Fixed priority to B, with a starvation guard for A.

---
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory/L2 port between the CPU's instruction port (A,
// read-only) and data port (B, read/write). One requester is granted at a
// time. Its request is forwarded unchanged to the memory side and held
// until mem_resp arrives. The requester then receives a one-cycle resp pulse
// together with registered read data.
//
// Arbitration (default build):
//   Port B has fixed priority. A 4-bit saturating starve_cnt counts B grants
//   taken while A is waiting. Once it reaches STARVE_LIMIT, A is granted next.
//
// Optional build macro ARB_ROUND_ROBIN_EN:
//   When both ports are pending, the port opposite to the last granted one
//   (rr_last) wins. In this build starve_cnt is removed and STARVE_LIMIT is
//   ignored.
//
// Parameters:
//   ADDR_W        address width
//   DATA_W        data width (byte mask width is DATA_W/8)
//   STARVE_LIMIT  consecutive B grants tolerated while A waits (1..15)
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   read_a, address_a             port A read request (held until resp_a)
//   resp_a, rdata_a               port A completion pulse and read data
//   read_b, write_b, wmask_b,
//   address_b, wdata_b            port B request (held until resp_b)
//   resp_b, rdata_b               port B completion pulse and read data
//   mem_read, mem_write,
//   mem_wmask, mem_address,
//   mem_wdata                     downstream request (registered)
//   mem_resp, mem_rdata           downstream one-cycle completion and data
//
// All outputs are registered. A transaction takes at least 3 cycles plus the
// memory latency: IDLE, GRANT (held until mem_resp), DONE.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                read_a,
  input  logic [ADDR_W-1:0]   address_a,
  output logic                resp_a,
  output logic [DATA_W-1:0]   rdata_a,

  input  logic                read_b,
  input  logic                write_b,
  input  logic [DATA_W/8-1:0] wmask_b,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic                resp_b,
  output logic [DATA_W-1:0]   rdata_b,

  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;

  // If both read_b and write_b are high, the write wins. The read is dropped,
  // and a single resp_b is returned.
  logic b_pend;
  logic pick_b;

  assign b_pend = read_b | write_b;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_last: 0 = A was granted last, 1 = B was granted last.
  logic rr_last;

  // With both ports pending, grant the port that did not win last time.
  assign pick_b = b_pend & (~read_a | ~rr_last);
`else
  localparam logic [3:0] STARVE_LIM4 = STARVE_LIMIT[3:0];

  logic [3:0] starve_cnt;

  // The counter sticks at 15 rather than wrapping. A wrap would silently
  // restore B's priority over a starving A.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // B keeps priority until A has watched STARVE_LIMIT B grants go by.
  assign pick_b = b_pend & ((starve_cnt < STARVE_LIM4) | ~read_a);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      resp_a      <= 1'b0;
      resp_b      <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wmask   <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last     <= 1'b0;
`else
      starve_cnt  <= 4'd0;
`endif
    end else begin
      // Responses are single-cycle pulses. They default low every cycle.
      resp_a <= 1'b0;
      resp_b <= 1'b0;

      case (state)
        // Stage boundary: the request is sampled here, and mem_* is driven
        // from the next cycle.
        IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
          if (!read_a) begin
            starve_cnt <= 4'd0;
          end
`endif
          if (pick_b) begin
            state       <= GRANT_B;
            mem_address <= address_b;
            mem_wdata   <= wdata_b;
            mem_wmask   <= wmask_b;
            mem_write   <= write_b;
            mem_read    <= ~write_b;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last     <= 1'b1;
`else
            if (read_a) begin
              starve_cnt <= sat_inc(starve_cnt);
            end
`endif
          end else if (read_a) begin
            state       <= GRANT_A;
            mem_address <= address_a;
            mem_wdata   <= '0;
            mem_wmask   <= {MASK_W{1'b0}};
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last     <= 1'b0;
`else
            starve_cnt  <= 4'd0;
`endif
          end
        end

        // Stage boundary: mem_* is held stable until the memory responds.
        // Dropping the request mid-grant does not abort the transaction.
        GRANT_A: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata_a   <= mem_rdata;
            resp_a    <= 1'b1;
            state     <= DONE;
          end
        end

        GRANT_B: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // Loaded on writes too. The requester ignores it.
            rdata_b   <= mem_rdata;
            resp_b    <= 1'b1;
            state     <= DONE;
          end
        end

        // Stage boundary: in this cycle the requester still holds the request
        // it has just been answered for. Skipping arbitration here prevents a
        // duplicate grant of that request.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. The memory side is driven step by
// step from the stimulus sequence. Expected values are hand-computed
// constants. The bench covers both the fixed-priority build and the
// ARB_ROUND_ROBIN_EN build.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit         T3_B_FIRST = 1'b0;          // rr_last = B after test 2
  localparam logic [5:0] STARVE_SEQ = 6'b101010;     // bit k = 1: grant k is B
`else
  localparam bit         T3_B_FIRST = 1'b1;
  localparam logic [5:0] STARVE_SEQ = 6'b101111;     // B B B B A B
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              read_a;
  logic [ADDR_W-1:0] address_a;
  logic              resp_a;
  logic [DATA_W-1:0] rdata_a;
  logic              read_b;
  logic              write_b;
  logic [MASK_W-1:0] wmask_b;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] wdata_b;
  logic              resp_b;
  logic [DATA_W-1:0] rdata_b;
  logic              mem_read;
  logic              mem_write;
  logic [MASK_W-1:0] mem_wmask;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int na = 0;
  int nb = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .read_a(read_a),
    .address_a(address_a),
    .resp_a(resp_a),
    .rdata_a(rdata_a),
    .read_b(read_b),
    .write_b(write_b),
    .wmask_b(wmask_b),
    .address_b(address_b),
    .wdata_b(wdata_b),
    .resp_b(resp_b),
    .rdata_b(rdata_b),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_wmask(mem_wmask),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Count response pulses so duplicate or missing pulses are caught.
  always @(negedge clk) begin
    if (resp_a === 1'b1) na++;
    if (resp_b === 1'b1) nb++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (mem_read === 1'b1 || mem_write === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  initial begin
    int na0;
    int nb0;
    bit ok;

    reset_n   = 1'b0;
    read_a    = 1'b0;
    address_a = '0;
    read_b    = 1'b0;
    write_b   = 1'b0;
    wmask_b   = '0;
    address_b = '0;
    wdata_b   = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_outputs", {resp_a, resp_b, mem_read, mem_write, mem_wmask}, 64'h0);
    chk("rst_mem_address", mem_address, 64'h0);
    chk("rst_rdata", {rdata_a, rdata_b}, 64'h0);
    reset_n = 1'b1;
    tick();

    // ---- test 1: single A read of 0x100 ----
    na0 = na; nb0 = nb;
    read_a = 1'b1; address_a = 32'h100;
    tick();
    chk("t1_mem_read", {mem_read, mem_write}, 64'b10);
    chk("t1_mem_address", mem_address, 64'h100);
    tick();
    chk("t1_mem_read_held", mem_read, 64'h1);
    mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_resp = 1'b0; mem_rdata = 32'h0;
    chk("t1_resp", {resp_a, resp_b}, 64'b10);
    chk("t1_rdata_a", rdata_a, 64'hDEADBEEF);
    chk("t1_done_no_strobe", {mem_read, mem_write}, 64'b00);
    tick();                                 // DONE: read_a still held
    chk("t1_resp_pulse_end", resp_a, 64'h0);
    read_a = 1'b0;
    tick();
    chk("t1_no_dup_grant", {mem_read, mem_write}, 64'b00);
    chk("t1_rdata_a_hold", rdata_a, 64'hDEADBEEF);
    chk("t1_resp_counts", {32'(na - na0), 32'(nb - nb0)}, {32'd1, 32'd0});

    // ---- test 2: B write of 0x200 ----
    na0 = na; nb0 = nb;
    write_b = 1'b1; address_b = 32'h200; wdata_b = 32'h12345678; wmask_b = 4'b0011;
    tick();
    chk("t2_strobes", {mem_read, mem_write}, 64'b01);
    chk("t2_mem_fields", {mem_address, mem_wdata}, {32'h200, 32'h12345678});
    chk("t2_mem_wmask", mem_wmask, 64'b0011);
    address_b = 32'hFFFF_FFFF; wdata_b = 32'h0; wmask_b = 4'b1111;   // capture must hold
    tick();
    chk("t2_held", {mem_address, mem_wdata}, {32'h200, 32'h12345678});
    chk("t2_held_mask", {mem_read, mem_write, mem_wmask}, {2'b01, 4'b0011});
    mem_resp = 1'b1; mem_rdata = 32'h0000CAFE;
    tick();
    mem_resp = 1'b0;
    chk("t2_resp", {resp_a, resp_b, mem_read, mem_write}, 64'b0100);
    chk("t2_rdata_b", rdata_b, 64'hCAFE);
    tick();
    write_b = 1'b0;
    chk("t2_resp_pulse_end", resp_b, 64'h0);
    tick();
    chk("t2_resp_counts", {32'(na - na0), 32'(nb - nb0)}, {32'd0, 32'd1});

    // ---- test 3: A and B in the same cycle, both held ----
    na0 = na; nb0 = nb;
    read_a = 1'b1; address_a = 32'h300;
    read_b = 1'b1; address_b = 32'h400;
    tick();
    chk("t3_first_addr", mem_address, T3_B_FIRST ? 64'h400 : 64'h300);
    chk("t3_first_read", mem_read, 64'h1);
    mem_resp = 1'b1; mem_rdata = 32'h1111;
    tick();
    mem_resp = 1'b0;
    chk("t3_first_resp", {resp_a, resp_b}, T3_B_FIRST ? 64'b01 : 64'b10);
    if (T3_B_FIRST) read_b = 1'b0; else read_a = 1'b0;
    tick();                                 // DONE
    chk("t3_done_no_strobe", mem_read, 64'h0);
    tick();                                 // other port granted right after DONE
    chk("t3_second_addr", mem_address, T3_B_FIRST ? 64'h300 : 64'h400);
    chk("t3_second_read", mem_read, 64'h1);
    mem_resp = 1'b1; mem_rdata = 32'h2222;
    tick();
    mem_resp = 1'b0;
    chk("t3_second_resp", {resp_a, resp_b}, T3_B_FIRST ? 64'b10 : 64'b01);
    read_a = 1'b0; read_b = 1'b0;
    tick();
    tick();
    chk("t3_rdata", {rdata_a, rdata_b},
        T3_B_FIRST ? {32'h2222, 32'h1111} : {32'h1111, 32'h2222});
    chk("t3_resp_counts", {32'(na - na0), 32'(nb - nb0)}, {32'd1, 32'd1});

    // ---- test 4: B continuously requesting while A is held ----
    read_a = 1'b1; address_a = 32'h500;
    read_b = 1'b1; address_b = 32'h600;
    for (int k = 0; k < 6; k++) begin
      wait_grant(ok);
      chk("t4_grant_seen", ok, 64'h1);
      chk("t4_grant_addr", mem_address, STARVE_SEQ[k] ? 64'h600 : 64'h500);
      mem_resp = 1'b1; mem_rdata = 32'(k);
      tick();
      mem_resp = 1'b0;
      chk("t4_resp", {resp_a, resp_b}, STARVE_SEQ[k] ? 64'b01 : 64'b10);
      chk("t4_done_no_strobe", {mem_read, mem_write}, 64'b00);
      tick();
      if (k == 5) begin
        read_a = 1'b0; read_b = 1'b0;
      end
    end
    tick();
    chk("t4_idle_after", {mem_read, mem_write}, 64'b00);

    // ---- test 5: reset during GRANT_B, then normal service ----
    write_b = 1'b1; address_b = 32'h700; wdata_b = 32'hAAAA; wmask_b = 4'hF;
    tick();
    chk("t5_granted", mem_write, 64'h1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_rst", {mem_read, mem_write, mem_wmask, resp_b}, 64'h0);
    chk("t5_async_rst_bus", {mem_address, mem_wdata}, 64'h0);
    write_b = 1'b0;
    tick();
    reset_n = 1'b1;
    mem_resp = 1'b1; mem_rdata = 32'hBAD0BAD0;   // late response, must be ignored
    tick();
    mem_resp = 1'b0;
    chk("t5_late_resp_ignored", {resp_a, resp_b}, 64'b00);
    chk("t5_rdata_b_clear", rdata_b, 64'h0);
    read_b = 1'b1; write_b = 1'b1; address_b = 32'h800; wdata_b = 32'h55; wmask_b = 4'b0100;
    tick();
    chk("t5_write_wins", {mem_read, mem_write}, 64'b01);
    chk("t5_addr", mem_address, 64'h800);
    mem_resp = 1'b1; mem_rdata = 32'h5A5A;
    tick();
    mem_resp = 1'b0;
    chk("t5_resp", {resp_a, resp_b}, 64'b01);
    chk("t5_rdata_b", rdata_b, 64'h5A5A);
    read_b = 1'b0; write_b = 1'b0;
    tick();
    tick();
    chk("t5_idle", {mem_read, mem_write, resp_b}, 64'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
